// File: rtl/lcs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcs_pkg
//  Description : Shared types, widths and helpers for the LCS sequencer
//  Revision    : 1.0 - initial release
// ============================================================================
package lcs_pkg;

  localparam int MAX_LEN = 16;
  localparam int IDX_W   = 5;
  localparam int DIR_W   = 2;
  localparam int LEN_W   = 8;

  localparam logic [IDX_W-1:0] MAX_LEN_IDX = IDX_W'(MAX_LEN);

  localparam logic [DIR_W-1:0] DIR_DIAG = 2'd0;
  localparam logic [DIR_W-1:0] DIR_LEFT = 2'd1;
  localparam logic [DIR_W-1:0] DIR_UP   = 2'd2;
  localparam logic [DIR_W-1:0] DIR_ILL  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_TB_INIT = 3'd3,
    ST_TB_RD   = 3'd4,
    ST_TB_WAIT = 3'd5,
    ST_DONE    = 3'd6
  } lcs_state_e;

  // Saturating decrement of a table index
  function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // Saturating decrement of an LCS length count
  function automatic logic [LEN_W-1:0] len_dec(input logic [LEN_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcs_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : lcs_sequencer_if
//  Description : Sequencer <-> DP datapath channel (fill, traceback, emit)
//  Revision    : 1.0 - initial release
// ============================================================================
interface lcs_sequencer_if;
  import lcs_pkg::*;

  logic             fill_valid;
  logic [IDX_W-1:0] fill_m;
  logic [IDX_W-1:0] fill_n;
  logic             fill_ready;
  logic [LEN_W-1:0] tab_len;
  logic             tb_rd;
  logic [IDX_W-1:0] tb_m;
  logic [IDX_W-1:0] tb_n;
  logic             dir_valid;
  logic [DIR_W-1:0] dir;
  logic             emit_valid;
  logic [IDX_W-1:0] emit_a_idx;
  logic [IDX_W-1:0] emit_pos;

  modport master (
    output fill_valid, fill_m, fill_n, tb_rd, tb_m, tb_n,
           emit_valid, emit_a_idx, emit_pos,
    input  fill_ready, tab_len, dir_valid, dir
  );

  modport slave (
    input  fill_valid, fill_m, fill_n, tb_rd, tb_m, tb_n,
           emit_valid, emit_a_idx, emit_pos,
    output fill_ready, tab_len, dir_valid, dir
  );

endinterface
`default_nettype wire

// File: rtl/lcs_fill_walker.sv
`default_nettype none
// ============================================================================
//  Module      : lcs_fill_walker
//  Description : Row-major (m,n) cell counter with stall and last-cell flag
//  Revision    : 1.0 - initial release
// ============================================================================
module lcs_fill_walker
  import lcs_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             adv_i,
  input  logic [IDX_W-1:0] len_a_i,
  input  logic [IDX_W-1:0] len_b_i,
  output logic [IDX_W-1:0] m_o,
  output logic [IDX_W-1:0] n_o,
  output logic             last_o
);

  logic [IDX_W-1:0] m_q, m_d;
  logic [IDX_W-1:0] n_q, n_d;

  assign m_o    = m_q;
  assign n_o    = n_q;
  assign last_o = (m_q == len_a_i) && (n_q == len_b_i);

  // Next cell: column runs fastest; the final cell parks the counter
  always_comb begin
    m_d = m_q;
    n_d = n_q;
    if (clear_i) begin
      m_d = '0;
      n_d = '0;
    end else if (adv_i && !last_o) begin
      if (n_q == len_b_i) begin
        n_d = '0;
        m_d = m_q + 1'b1;
      end else begin
        n_d = n_q + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_q <= '0;
      n_q <= '0;
    end else begin
      m_q <= m_d;
      n_q <= n_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcs_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lcs_sequencer
//  Description : Sequences the LCS DP table fill and the traceback that emits
//                LCS characters with their positions
//  Revision    : 1.0 - initial release
// ============================================================================
module lcs_sequencer
  import lcs_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [IDX_W-1:0] len_a_i,
  input  logic [IDX_W-1:0] len_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] lcs_len_o,
  lcs_sequencer_if.master  dp
);

  lcs_state_e       state_q, state_d;
  logic [IDX_W-1:0] len_a_q, len_a_d;
  logic [IDX_W-1:0] len_b_q, len_b_d;
  logic [IDX_W-1:0] tbm_q, tbm_d;
  logic [IDX_W-1:0] tbn_q, tbn_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] lcs_len_q, lcs_len_d;
  logic             err_q, err_d;

  logic             w_start_acc;
  logic             w_fill_acc;
  logic [IDX_W-1:0] w_walk_m;
  logic [IDX_W-1:0] w_walk_n;
  logic             w_walk_last;
  logic [IDX_W-1:0] w_m_nx;
  logic [IDX_W-1:0] w_n_nx;
  logic [LEN_W-1:0] w_rem_nx;

  assign w_fill_acc = (state_q == ST_FILL) && dp.fill_ready;

  lcs_fill_walker u_walker (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (w_start_acc),
    .adv_i   (w_fill_acc),
    .len_a_i (len_a_q),
    .len_b_i (len_b_q),
    .m_o     (w_walk_m),
    .n_o     (w_walk_n),
    .last_o  (w_walk_last)
  );

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign err_o     = err_q;
  assign lcs_len_o = lcs_len_q;
  assign dp.fill_m = w_walk_m;
  assign dp.fill_n = w_walk_n;
  assign dp.tb_m   = tbm_q;
  assign dp.tb_n   = tbn_q;

  // Next-state, datapath strobes and traceback step decode
  always_comb begin
    state_d        = state_q;
    len_a_d        = len_a_q;
    len_b_d        = len_b_q;
    tbm_d          = tbm_q;
    tbn_d          = tbn_q;
    rem_d          = rem_q;
    lcs_len_d      = lcs_len_q;
    err_d          = err_q;
    w_start_acc    = 1'b0;
    w_m_nx         = tbm_q;
    w_n_nx         = tbn_q;
    w_rem_nx       = rem_q;
    dp.fill_valid  = 1'b0;
    dp.tb_rd       = 1'b0;
    dp.emit_valid  = 1'b0;
    dp.emit_a_idx  = '0;
    dp.emit_pos    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          w_start_acc = 1'b1;
          len_a_d     = len_a_i;
          len_b_d     = len_b_i;
          lcs_len_d   = '0;
          err_d       = 1'b0;
          // Oversized strings cannot be tabled: flag and finish immediately
          if ((len_a_i > MAX_LEN_IDX) || (len_b_i > MAX_LEN_IDX)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        dp.fill_valid = 1'b1;
        if (dp.fill_ready && w_walk_last) begin
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        state_d = ST_TB_INIT;
      end

      ST_TB_INIT: begin
        lcs_len_d = dp.tab_len;
        rem_d     = dp.tab_len;
        tbm_d     = len_a_q;
        tbn_d     = len_b_q;
        // An empty string also ends traceback, whatever the table says
        if ((dp.tab_len == '0) || (len_a_q == '0) || (len_b_q == '0)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_TB_RD;
        end
      end

      ST_TB_RD: begin
        dp.tb_rd = 1'b1;
        state_d  = ST_TB_WAIT;
      end

      ST_TB_WAIT: begin
        if (dp.dir_valid) begin
          case (dp.dir)
            DIR_DIAG: begin
              dp.emit_valid = 1'b1;
              dp.emit_a_idx = idx_dec(tbm_q);
              dp.emit_pos   = IDX_W'(len_dec(rem_q));
              w_m_nx        = idx_dec(tbm_q);
              w_n_nx        = idx_dec(tbn_q);
              w_rem_nx      = len_dec(rem_q);
            end
            DIR_LEFT: begin
              w_n_nx = idx_dec(tbn_q);
            end
            default: begin
              // Illegal code is flagged but walked as an up move
              w_m_nx = idx_dec(tbm_q);
              if (dp.dir == DIR_ILL) begin
                err_d = 1'b1;
              end
            end
          endcase
          tbm_d = w_m_nx;
          tbn_d = w_n_nx;
          rem_d = w_rem_nx;
          if ((w_rem_nx == '0) || (w_m_nx == '0) || (w_n_nx == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_TB_RD;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      len_a_q   <= '0;
      len_b_q   <= '0;
      tbm_q     <= '0;
      tbn_q     <= '0;
      rem_q     <= '0;
      lcs_len_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_a_q   <= len_a_d;
      len_b_q   <= len_b_d;
      tbm_q     <= tbm_d;
      tbn_q     <= tbn_d;
      rem_q     <= rem_d;
      lcs_len_q <= lcs_len_d;
      err_q     <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcs_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcs_sequencer
//  Description : Directed self-checking bench with a DP datapath model and
//                fill/emit scoreboards
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lcs_sequencer;
  import lcs_pkg::*;

  logic             clk;
  logic             reset_n;
  logic             start_i;
  logic [IDX_W-1:0] len_a_i;
  logic [IDX_W-1:0] len_b_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [LEN_W-1:0] lcs_len_o;

  lcs_sequencer_if dp ();

  lcs_sequencer u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (start_i),
    .len_a_i   (len_a_i),
    .len_b_i   (len_b_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .lcs_len_o (lcs_len_o),
    .dp        (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  byte        sa [0:16];
  byte        sb [0:16];
  int         cur_la, cur_lb;
  logic [7:0] lenT [0:16][0:16];
  logic [1:0] dirT [0:16][0:16];
  int         rL   [0:16][0:16];
  int         rD   [0:16][0:16];
  int         fillq [$];
  int         emitq [$];
  int         fill_cnt, emit_cnt, done_cnt, tbrd_cnt, busy_cnt, exp_steps;
  int         ready_mode, dir_dly, rphase, cd;
  bit         ill_once, pend;
  logic [IDX_W-1:0] hold_m, hold_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Datapath model: writes a cell of its own table on each accepted fill
  task automatic model_cell(input int i, input int j);
    if (i == 0 || j == 0) begin
      lenT[i][j] = 8'd0;
      dirT[i][j] = 2'd2;
    end else if (sa[i-1] == sb[j-1]) begin
      lenT[i][j] = lenT[i-1][j-1] + 8'd1;
      dirT[i][j] = 2'd0;
    end else if (lenT[i-1][j] >= lenT[i][j-1]) begin
      lenT[i][j] = lenT[i-1][j];
      dirT[i][j] = 2'd2;
    end else begin
      lenT[i][j] = lenT[i][j-1];
      dirT[i][j] = 2'd1;
    end
  endtask

  // Datapath responder and output monitor: sample at negedge, drive after posedge
  initial begin
    dp.fill_ready = 1'b1;
    dp.tab_len    = 8'd0;
    dp.dir_valid  = 1'b0;
    dp.dir        = 2'd0;
    pend = 1'b0;
    cd   = 0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (dp.fill_valid && dp.fill_ready) begin
          fill_cnt++;
          if (fillq.size() == 0) check("fill_unexpected", 32'd1, 32'd0);
          else check("fill_cell", 32'(int'(dp.fill_m) * 32 + int'(dp.fill_n)), 32'(fillq.pop_front()));
          if (dp.fill_m <= 5'd16 && dp.fill_n <= 5'd16) model_cell(int'(dp.fill_m), int'(dp.fill_n));
        end
        if (dp.tb_rd) begin
          tbrd_cnt++;
          pend   = 1'b1;
          cd     = dir_dly;
          hold_m = dp.tb_m;
          hold_n = dp.tb_n;
        end else if (pend) begin
          check("tb_m_hold", 32'(dp.tb_m), 32'(hold_m));
          check("tb_n_hold", 32'(dp.tb_n), 32'(hold_n));
        end
        if (dp.emit_valid) begin
          emit_cnt++;
          if (emitq.size() == 0) check("emit_unexpected", 32'd1, 32'd0);
          else check("emit", 32'(int'(dp.emit_a_idx) * 32 + int'(dp.emit_pos)), 32'(emitq.pop_front()));
        end
        if (done_o) done_cnt++;
        if (busy_o) busy_cnt++;
      end else begin
        pend = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!reset_n) begin
        pend         = 1'b0;
        dp.dir_valid = 1'b0;
      end else if (pend) begin
        if (cd <= 1) begin
          dp.dir_valid = 1'b1;
          dp.dir       = ill_once ? 2'd3 : dirT[hold_m][hold_n];
          ill_once     = 1'b0;
          pend         = 1'b0;
        end else begin
          cd--;
          dp.dir_valid = 1'b0;
        end
      end else begin
        dp.dir_valid = 1'b0;
      end
      rphase++;
      dp.fill_ready = (ready_mode == 0) ? 1'b1 : ((rphase % 3) == 0);
      dp.tab_len    = (cur_la <= 16 && cur_lb <= 16) ? lenT[cur_la][cur_lb] : 8'd0;
    end
  end

  // Load strings, build the reference LCS and push expected fill/emit order
  task automatic prep(input string a, input string b, input int rmode, input int dly, input bit ill);
    int i, j, rem, d;
    bit first;
    cur_la = a.len();
    cur_lb = b.len();
    for (int k = 0; k < cur_la; k++) sa[k] = a[k];
    for (int k = 0; k < cur_lb; k++) sb[k] = b[k];
    for (int x = 0; x <= 16; x++)
      for (int y = 0; y <= 16; y++) begin
        lenT[x][y] = 8'hEE;
        dirT[x][y] = 2'd3;
      end
    fillq.delete();
    emitq.delete();
    fill_cnt = 0; emit_cnt = 0; done_cnt = 0; tbrd_cnt = 0; busy_cnt = 0;
    rphase = 0; ready_mode = rmode; dir_dly = dly; ill_once = ill;
    for (int x = 0; x <= cur_la; x++)
      for (int y = 0; y <= cur_lb; y++) begin
        fillq.push_back(x * 32 + y);
        if (x == 0 || y == 0) begin
          rL[x][y] = 0; rD[x][y] = 2;
        end else if (a[x-1] == b[y-1]) begin
          rL[x][y] = rL[x-1][y-1] + 1; rD[x][y] = 0;
        end else if (rL[x-1][y] >= rL[x][y-1]) begin
          rL[x][y] = rL[x-1][y]; rD[x][y] = 2;
        end else begin
          rL[x][y] = rL[x][y-1]; rD[x][y] = 1;
        end
      end
    i = cur_la; j = cur_lb; rem = rL[cur_la][cur_lb]; first = ill; exp_steps = 0;
    while (rem > 0 && i > 0 && j > 0) begin
      d = rD[i][j];
      if (first) begin d = 2; first = 1'b0; end
      exp_steps++;
      if (d == 0) begin
        emitq.push_back((i - 1) * 32 + rem - 1);
        i--; j--; rem--;
      end else if (d == 1) j--;
      else i--;
    end
  endtask

  task automatic start_op(input int la, input int lb);
    @(posedge clk); #1;
    start_i = 1'b1;
    len_a_i = IDX_W'(la);
    len_b_i = IDX_W'(lb);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("done_within_budget", 32'(done_cnt != 0), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_case(input string a, input string b, input int rmode, input int dly,
                         input bit ill, input bit poke, input bit exp_err);
    int cells;
    prep(a, b, rmode, dly, ill);
    cells = (cur_la + 1) * (cur_lb + 1);
    start_op(cur_la, cur_lb);
    if (poke) begin
      repeat (4) @(posedge clk);
      #1;
      start_i = 1'b1; len_a_i = 5'd2; len_b_i = 5'd1;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    wait_done(3000);
    check("fill_count", 32'(fill_cnt), 32'(cells));
    check("fill_left", 32'(fillq.size()), 32'd0);
    check("lcs_len", 32'(lcs_len_o), 32'(rL[cur_la][cur_lb]));
    check("emit_left", 32'(emitq.size()), 32'd0);
    check("done_once", 32'(done_cnt), 32'd1);
    check("err", 32'(err_o), 32'(exp_err));
    check("busy_after", 32'(busy_o), 32'd0);
    if (cur_la == 0 || cur_lb == 0) check("tb_rd_none", 32'(tbrd_cnt), 32'd0);
    else check("tb_rd_count", 32'(tbrd_cnt), 32'(exp_steps));
    if (rmode == 0 && dly == 1 && !poke)
      check("latency", 32'(busy_cnt), 32'(cells + 3 + 2 * exp_steps));
  endtask

  initial begin
    int c, d0;
    reset_n = 1'b0; start_i = 1'b0; len_a_i = '0; len_b_i = '0;
    cur_la = 0; cur_lb = 0; ready_mode = 0; dir_dly = 1; ill_once = 1'b0;
    fill_cnt = 0; emit_cnt = 0; done_cnt = 0; tbrd_cnt = 0; busy_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_lcs_len", 32'(lcs_len_o), 32'd0);
    check("rst_fill_valid", 32'(dp.fill_valid), 32'd0);
    check("rst_tb_rd", 32'(dp.tb_rd), 32'd0);
    check("rst_emit", 32'(dp.emit_valid), 32'd0);
    reset_n = 1'b1;

    // Reference strings, full-rate handshake
    do_case("ABCBDAB", "BDCABA", 0, 1, 1'b0, 1'b0, 1'b0);
    check("case1_len4", 32'(lcs_len_o), 32'd4);
    check("case1_emits", 32'(emit_cnt), 32'd4);
    // Same strings with a stalling datapath
    do_case("ABCBDAB", "BDCABA", 1, 1, 1'b0, 1'b0, 1'b0);
    check("case2_emits", 32'(emit_cnt), 32'd4);
    // Empty string A
    do_case("", "ABCDE", 0, 1, 1'b0, 1'b0, 1'b0);
    check("case3_cells", 32'(fill_cnt), 32'd6);
    // Identical strings, slow direction reads
    do_case("XYZ", "XYZ", 0, 3, 1'b0, 1'b0, 1'b0);
    check("case4_emits", 32'(emit_cnt), 32'd3);
    // Start while busy must be ignored
    do_case("ABCB", "BCA", 0, 1, 1'b0, 1'b1, 1'b0);

    // Reset during traceback wait
    prep("ABCBDAB", "BDCABA", 0, 3, 1'b0);
    start_op(cur_la, cur_lb);
    c = 0;
    while (tbrd_cnt == 0 && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    check("reached_traceback", 32'(tbrd_cnt != 0), 32'd1);
    d0 = done_cnt;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_fill_valid", 32'(dp.fill_valid), 32'd0);
    check("midrst_tb_rd", 32'(dp.tb_rd), 32'd0);
    check("midrst_lcs_len", 32'(lcs_len_o), 32'd0);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt), 32'(d0));
    check("midrst_idle", 32'(busy_o), 32'd0);
    fillq.delete();
    emitq.delete();

    // Illegal direction once: flagged, walked as up
    do_case("XYZ", "XYZ", 0, 1, 1'b1, 1'b0, 1'b1);
    check("ill_emits", 32'(emit_cnt), 32'd2);
    // Next start clears the sticky error
    do_case("AB", "B", 0, 1, 1'b0, 1'b0, 1'b0);

    // Oversized length: error, done, no fill
    prep("", "ABC", 0, 1, 1'b0);
    fillq.delete();
    cur_la = 17;
    start_op(17, 3);
    wait_done(50);
    check("big_fill_none", 32'(fill_cnt), 32'd0);
    check("big_err", 32'(err_o), 32'd1);
    check("big_done_once", 32'(done_cnt), 32'd1);
    check("big_busy_cycles", 32'(busy_cnt), 32'd1);
    check("big_lcs_len", 32'(lcs_len_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
